fir_tap_sequencer: RTL and testbench

Controller for the FIR filter datapath. On each accepted ADC sample it stores the sample in a circular delay-line RAM. It then walks all N taps, driving sample-RAM and coefficient-ROM addresses together, and accumulates the products in an internal MAC. Finally it emits one saturated filtered output. It sits between the ADC capture logic and the filter output, and replaces free-running coefficient counting with a start/finish-sequenced tap sweep.

---
 rtl/fir_pkg.sv | 46 ++++
 rtl/fir_tap_mac.sv | 64 ++++++
 rtl/fir_tap_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR tap sequencer:
//   - state_t      : controller states
//   - FIR_*        : default datapath widths and output scaling shift
//   - sat_shift()  : arithmetic right shift followed by saturation to a
//                    signed out_w-bit range (computed on a 64-bit carrier so
//                    one function serves any accumulator width up to 63)
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_DATA_W = 12;
    localparam int FIR_COEF_W = 16;
    localparam int FIR_ACC_W  = 40;
    localparam int FIR_OUT_W  = 16;
    localparam int FIR_SHIFT  = 15;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] acc,
        input int                 shift,
        input int                 out_w
    );
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        shifted = acc >>> shift;
        max_v   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (out_w - 1));
        if (shifted > max_v) begin
            return max_v;
        end else if (shifted < min_v) begin
            return min_v;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/fir_tap_mac.sv
// ---------------------------------------------------------------------------
// fir_tap_mac
// Two-stage multiply-accumulate behind synchronous sample RAM / coefficient
// ROM reads. An issue in cycle t has its operands on smp_in/coef_in in t+1,
// the registered product in t+2, and is added into the accumulator at the
// end of t+2. A valid bit follows each issue so idle cycles add nothing.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-low reset
//   clr_in         : zero the accumulator (no product may be in flight)
//   issue_in       : an operand read was issued this cycle
//   smp_in/coef_in : signed operands, one cycle after the issue
//   acc_out        : running signed accumulator
// ---------------------------------------------------------------------------
module fir_tap_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int COEF_W = FIR_COEF_W,
    parameter int ACC_W  = FIR_ACC_W
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     clr_in,
    input  logic                     issue_in,
    input  logic signed [DATA_W-1:0] smp_in,
    input  logic signed [COEF_W-1:0] coef_in,
    output logic signed [ACC_W-1:0]  acc_out
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic                     data_valid_reg;
    logic                     prod_valid_reg;
    logic signed [PROD_W-1:0] prod_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [PROD_W-1:0] smp_ext;
    logic signed [PROD_W-1:0] coef_ext;

    // Operands widened to the full product width; the low PROD_W bits of the
    // product are exact for signed operands of these widths.
    assign smp_ext  = {{COEF_W{smp_in[DATA_W-1]}}, smp_in};
    assign coef_ext = {{DATA_W{coef_in[COEF_W-1]}}, coef_in};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            data_valid_reg <= 1'b0;
            prod_valid_reg <= 1'b0;
            prod_reg       <= '0;
            acc_reg        <= '0;
        end else begin
            data_valid_reg <= issue_in;
            prod_valid_reg <= data_valid_reg;
            prod_reg       <= smp_ext * coef_ext;
            if (clr_in) begin
                acc_reg <= '0;
            end else if (prod_valid_reg) begin
                acc_reg <= acc_reg + {{(ACC_W - PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
            end
        end
    end

    assign acc_out = acc_reg;

endmodule

// File: rtl/fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer
// FIR controller: zeroes the delay line after reset, then for every accepted
// sample writes it into the circular sample RAM, sweeps all N taps (newest
// sample against coefficient 0), drains the MAC and emits one saturated
// result.
// Ports:
//   clk_in, rst_in                 : clock, asynchronous active-low reset
//   sample_valid_in, sample_in     : ADC sample strobe and data
//   busy_out, overrun_out          : not idle / strobe dropped this cycle
//   smp_we/waddr/wdata_out         : sample RAM write port
//   smp_raddr_out, smp_rdata_in    : sample RAM read port (1-cycle latency)
//   coef_addr_out, coef_data_in    : coefficient ROM (1-cycle latency)
//   result_out, result_valid_out   : held result, one-cycle update pulse
// ---------------------------------------------------------------------------
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int N          = 50,
    parameter int DATA_W     = FIR_DATA_W,
    parameter int COEF_W     = FIR_COEF_W,
    parameter int ACC_W      = FIR_ACC_W,
    parameter int OUT_W      = FIR_OUT_W,
    parameter int SHIFT      = FIR_SHIFT
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  sample_valid_in,
    input  logic [DATA_W-1:0]     sample_in,
    output logic                  busy_out,
    output logic                  overrun_out,
    output logic                  smp_we_out,
    output logic [ADDR_WIDTH-1:0] smp_waddr_out,
    output logic [DATA_W-1:0]     smp_wdata_out,
    output logic [ADDR_WIDTH-1:0] smp_raddr_out,
    input  logic [DATA_W-1:0]     smp_rdata_in,
    output logic [ADDR_WIDTH-1:0] coef_addr_out,
    input  logic [COEF_W-1:0]     coef_data_in,
    output logic [OUT_W-1:0]      result_out,
    output logic                  result_valid_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);

    state_t                  state_reg,  state_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg,    cnt_next;     // init address / tap k / drain count
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0]   rd_ptr_reg, rd_ptr_next;  // tracks (wr_ptr - k) mod N
    logic [DATA_W-1:0]       sample_reg, sample_next;
    logic [OUT_W-1:0]        hold_reg,   hold_next;
    // Low while reset is held and for the first edge after release, so every
    // output reads 0 during reset even though the state already says INIT.
    logic                    live_reg;

    logic                    mac_clr;
    logic                    mac_issue;
    logic signed [ACC_W-1:0] acc;
    logic signed [63:0]      acc_ext;
    logic [OUT_W-1:0]        sat_res;

    fir_tap_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clr_in   (mac_clr),
        .issue_in (mac_issue),
        .smp_in   ($signed(smp_rdata_in)),
        .coef_in  ($signed(coef_data_in)),
        .acc_out  (acc)
    );

    assign acc_ext = {{(64 - ACC_W){acc[ACC_W-1]}}, acc};
    assign sat_res = OUT_W'(sat_shift(acc_ext, SHIFT, OUT_W));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg  <= S_INIT;
            cnt_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            sample_reg <= '0;
            hold_reg   <= '0;
            live_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            sample_reg <= sample_next;
            hold_reg   <= hold_next;
            live_reg   <= 1'b1;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        sample_next      = sample_reg;
        hold_next        = hold_reg;
        busy_out         = 1'b0;
        overrun_out      = live_reg && sample_valid_in && (state_reg != S_IDLE);
        smp_we_out       = 1'b0;
        smp_waddr_out    = '0;
        smp_wdata_out    = '0;
        smp_raddr_out    = '0;
        coef_addr_out    = '0;
        result_out       = hold_reg;
        result_valid_out = 1'b0;
        mac_clr          = 1'b0;
        mac_issue        = 1'b0;

        case (state_reg)
            S_INIT: begin
                if (live_reg) begin
                    busy_out      = 1'b1;
                    smp_we_out    = 1'b1;
                    smp_waddr_out = cnt_reg;
                    if (cnt_reg == LAST) begin
                        cnt_next   = '0;
                        state_next = S_IDLE;
                    end else begin
                        cnt_next = cnt_reg + ONE_A;
                    end
                end
            end
            S_IDLE: begin
                if (sample_valid_in) begin
                    sample_next = sample_in;
                    state_next  = S_WRITE;
                end
            end
            S_WRITE: begin
                busy_out      = 1'b1;
                smp_we_out    = 1'b1;
                smp_waddr_out = wr_ptr_reg;
                smp_wdata_out = sample_reg;
                mac_clr       = 1'b1;
                cnt_next      = '0;
                rd_ptr_next   = wr_ptr_reg;
                state_next    = S_RUN;
            end
            S_RUN: begin
                busy_out      = 1'b1;
                mac_issue     = 1'b1;
                smp_raddr_out = rd_ptr_reg;
                coef_addr_out = cnt_reg;
                // Walk backwards through the delay line, wrapping at N.
                rd_ptr_next   = (rd_ptr_reg == '0) ? LAST : rd_ptr_reg - ONE_A;
                if (cnt_reg == LAST) begin
                    cnt_next   = '0;
                    state_next = S_DRAIN;
                end else begin
                    cnt_next = cnt_reg + ONE_A;
                end
            end
            S_DRAIN: begin
                busy_out = 1'b1;
                if (cnt_reg == ONE_A) begin
                    cnt_next   = '0;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + ONE_A;
                end
            end
            S_DONE: begin
                busy_out         = 1'b1;
                result_valid_out = 1'b1;
                result_out       = sat_res;
                hold_next        = sat_res;
                wr_ptr_next      = (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + ONE_A;
                state_next       = S_IDLE;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_sequencer
// Directed sequence with random samples/coefficients against a reference
// model that keeps the delay line as a queue (newest first) and computes
// each output as a plain dot product, shift and clamp.
// ---------------------------------------------------------------------------
module tb_fir_tap_sequencer;

    localparam int AW = 8;
    localparam int N  = 50;
    localparam int DW = 12;
    localparam int CW = 16;
    localparam int OW = 16;
    localparam int SH = 15;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          sample_valid_in = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          busy_out, overrun_out, smp_we_out, result_valid_out;
    logic [AW-1:0] smp_waddr_out, smp_raddr_out, coef_addr_out;
    logic [DW-1:0] smp_wdata_out, smp_rdata_in;
    logic [CW-1:0] coef_data_in;
    logic [OW-1:0] result_out;

    logic [DW-1:0] ram [0:255];
    logic [CW-1:0] rom [0:255];

    int coef_tab [N];
    int hist [$];
    int wr_count;
    int n_tx  = 0;
    int total = 0;
    int bad   = 0;
    int y;

    fir_tap_sequencer #(
        .ADDR_WIDTH (AW), .N (N), .DATA_W (DW), .COEF_W (CW),
        .ACC_W (40), .OUT_W (OW), .SHIFT (SH)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .sample_valid_in  (sample_valid_in),
        .sample_in        (sample_in),
        .busy_out         (busy_out),
        .overrun_out      (overrun_out),
        .smp_we_out       (smp_we_out),
        .smp_waddr_out    (smp_waddr_out),
        .smp_wdata_out    (smp_wdata_out),
        .smp_raddr_out    (smp_raddr_out),
        .smp_rdata_in     (smp_rdata_in),
        .coef_addr_out    (coef_addr_out),
        .coef_data_in     (coef_data_in),
        .result_out       (result_out),
        .result_valid_out (result_valid_out)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous sample RAM and coefficient ROM.
    always @(posedge clk_in) begin
        if (smp_we_out) ram[smp_waddr_out] <= smp_wdata_out;
        smp_rdata_in <= ram[smp_raddr_out];
        coef_data_in <= rom[coef_addr_out];
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: impulse-test taps, 1: random, 2: all full-scale positive
    task automatic load_coefs(input int mode);
        int v;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       v = (i < 4) ? (16384 >> i) : 0;
                1:       v = int'($urandom_range(0, 65535)) - 32768;
                default: v = 32767;
            endcase
            coef_tab[i] = v;
            rom[i]      = v[CW-1:0];
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < N; i++) hist.push_back(0);
        wr_count = 0;
    endtask

    task automatic model_push(input int s, output int y_exp);
        longint acc;
        hist.push_front(s);
        if (hist.size() > N) void'(hist.pop_back());
        acc = 0;
        for (int k = 0; k < N; k++) acc += longint'(hist[k]) * longint'(coef_tab[k]);
        acc = acc >>> SH;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        y_exp = int'(acc);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  busy_out, 0);
        chk({tag, "_ovr"},   overrun_out, 0);
        chk({tag, "_we"},    smp_we_out, 0);
        chk({tag, "_waddr"}, smp_waddr_out, 0);
        chk({tag, "_wdata"}, smp_wdata_out, 0);
        chk({tag, "_raddr"}, smp_raddr_out, 0);
        chk({tag, "_caddr"}, coef_addr_out, 0);
        chk({tag, "_res"},   result_out, 0);
        chk({tag, "_rv"},    result_valid_out, 0);
    endtask

    // Release reset and verify the N-cycle zeroing sweep.
    task automatic init_check();
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int c = 0; c <= N; c++) begin
            @(negedge clk_in);
            #1;
            if (c < N) begin
                chk("init_busy",  busy_out, 1);
                chk("init_we",    smp_we_out, 1);
                chk("init_waddr", smp_waddr_out, c);
                chk("init_wdata", smp_wdata_out, 0);
            end else begin
                chk("init_end_busy", busy_out, 0);
                chk("init_end_we",   smp_we_out, 0);
            end
        end
        model_reset();
        $display("init sweep: %0d cycles checked", N);
    endtask

    // One sample: strobe in IDLE, then check every cycle up to DONE.
    task automatic run_sample(input int s, input bit ovr, input int rst_at, output int y_obs);
        int y_exp;
        int exp_wa;
        int k;
        y_obs = 0;
        @(negedge clk_in);
        sample_valid_in = 1'b1;
        sample_in       = s[DW-1:0];
        #1;
        chk("idle_busy", busy_out, 0);
        chk("idle_ovr",  overrun_out, 0);
        exp_wa = wr_count % N;
        for (int c = 1; c <= N + 4; c++) begin
            @(negedge clk_in);
            sample_valid_in = ovr && (c == 7 || c == N + 4);
            sample_in       = 12'($urandom);
            if (c == rst_at) rst_in = 1'b0;
            #1;
            if (c == rst_at) begin
                check_all_zero("midrst");
                sample_valid_in = 1'b0;
                $display("sample %0d: in=%0d reset at cycle %0d", n_tx, s, c);
                n_tx++;
                return;
            end
            chk("busy", busy_out, 1);
            chk("overrun", overrun_out, sample_valid_in);
            chk("result_valid", result_valid_out, c == N + 4);
            if (c == 1) begin
                chk("we",    smp_we_out, 1);
                chk("waddr", smp_waddr_out, exp_wa);
                chk("wdata", $signed(smp_wdata_out), s);
            end else begin
                chk("we_off", smp_we_out, 0);
            end
            if (c >= 2 && c <= N + 1) begin
                k = c - 2;
                chk("raddr", smp_raddr_out, ((exp_wa - k) % N + N) % N);
                chk("caddr", coef_addr_out, k);
            end else begin
                chk("raddr_idle", smp_raddr_out, 0);
                chk("caddr_idle", coef_addr_out, 0);
            end
            if (c == N + 4) y_obs = int'($signed(result_out));
        end
        model_push(s, y_exp);
        wr_count++;
        chk("result", y_obs, y_exp);
        $display("sample %0d: in=%0d waddr=%0d result=%0d expected=%0d", n_tx, s, exp_wa, y_obs, y_exp);
        n_tx++;
    endtask

    initial begin
        int imp_exp [5];
        imp_exp = '{500, 250, 125, 62, 0};

        // Reset held: every output 0.
        load_coefs(0);
        repeat (2) @(negedge clk_in);
        #1;
        check_all_zero("reset");
        init_check();

        // Impulse response through the first four taps.
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 1000 : 0, 1'b0, -1, y);
            chk("impulse", y, imp_exp[i]);
        end

        // Random samples and taps, enough to wrap the write pointer, with
        // dropped strobes in RUN and DONE on some samples.
        load_coefs(1);
        for (int i = 0; i < 60; i++) begin
            run_sample(int'($urandom_range(0, 4095)) - 2048, (i % 7) == 3, -1, y);
        end

        // Saturation at both rails.
        load_coefs(2);
        for (int i = 0; i < N; i++) run_sample(2047, 1'b0, -1, y);
        chk("sat_pos", $signed(result_out), 32767);
        for (int i = 0; i < N; i++) run_sample(-2048, 1'b0, -1, y);
        chk("sat_neg", $signed(result_out), -32768);

        // Reset during RUN at k=10: no result, sweep restarts.
        load_coefs(1);
        run_sample(int'($urandom_range(0, 4095)) - 2048, 1'b0, 12, y);
        repeat (3) begin
            @(negedge clk_in);
            #1;
            chk("rst_hold_rv",   result_valid_out, 0);
            chk("rst_hold_busy", busy_out, 0);
        end
        init_check();
        for (int i = 0; i < 8; i++) begin
            run_sample(int'($urandom_range(0, 4095)) - 2048, i == 2, -1, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
